pipe_issue_unit: RTL
====================

// Module: pipe_issue_unit
// PURPOSE
// - Initiator side of the 4-stage register/ALU/memory pipeline: holds a small program of packed instructions and
//   issues one per cycle on the pipeline's rs1/rs2/rd/func/addr inputs.
// - Replaces hand-timed stimulus.
// - Inserts bubbles on read-after-write hazards against in-flight destinations; reports stalls and completion.
// PARAMETERS
// - PROG_DEPTH  16    program words; power of 2
// - PAW         4     program address width = log2(PROG_DEPTH)
// - HAZ_DEPTH   2     issued instructions tracked as in flight, i.e. results not yet in regbank
// - HLT_FUNC    4'hF  func code that ends the program; never issued
// PORTS
// - clk1        in   1   single pipeline clock, rising edge
// - rst         in   1   asynchronous, active-high reset
// - prog_we     in   1   program write strobe; honoured only in IDLE
// - prog_waddr  in   PAW program write address
// - prog_wdata  in   24  {func[23:20], rd[19:16], rs1[15:12], rs2[11:8], addr[7:0]}
// - start       in   1   begin execution at pc=0; honoured only in IDLE
// - abort       in   1   synchronous abort; any state -> IDLE
// - rs1,rs2,rd  out  4   register fields to pipeline, registered
// - func        out  4   ALU function to pipeline, registered
// - addr        out  8   memory address to pipeline, registered
// - issue_valid out  1   1 = fields hold a real instruction this cycle; 0 = bubble, pipeline must not write
// - busy        out  1   state != IDLE
// - done        out  1   one-cycle pulse when program fully drained
// - stall_cnt   out  8   bubbles inserted this run; saturates at 255
// BEHAVIOUR
// - Reset (async):
//   - State IDLE; pc=0; window cleared.
//   - All outputs 0, including done, stall_cnt and issue_valid.
//   - Program memory contents unaffected.
// - States: IDLE -> RUN -> DRAIN -> DONE -> IDLE.
// - IDLE:
//   - prog_we writes mem[prog_waddr] at the edge.
//   - start=1 -> RUN; pc<=0; stall_cnt<=0; window cleared.
//   - If start and prog_we are both high, the write is taken and start is ignored.
// - RUN, each edge, with w=mem[pc]:
//   - w.func==HLT_FUNC -> DRAIN. issue_valid<=0, window shifts in invalid.
//   - Hazard: w.rs1 or w.rs2 equals rd of any valid window entry.
//     - issue_valid<=0; fields hold previous values; pc holds.
//     - Window shifts in invalid; stall_cnt++ (saturating).
//   - Otherwise issue: fields<=w; issue_valid<=1; window shifts in {valid,w.rd}.
//     - pc==PROG_DEPTH-1 -> DRAIN (no wrap); else pc++.
// - Latency:
//   - start sampled at edge N; first issue_valid=1 in the cycle after edge N+1.
//   - Dependent instruction issues no earlier than 3 cycles after its producer (HAZ_DEPTH=2).
// - DRAIN:
//   - issue_valid=0; counts 4 cycles so the last issue completes its mem write, then -> DONE.
// - DONE: done=1 for exactly one cycle; -> IDLE next edge. stall_cnt holds until next start.
// - abort=1 at an edge:
//   - Any state -> IDLE; issue_valid<=0; window cleared; done stays 0. Priority over every other transition.
// - Outputs change only on clk1 edges; no combinational paths from inputs to outputs.
// TESTING
// - Load {ADD r10=r3+r5 @125; MUL r12=r3*r8 @126; HLT}, start -> 2 issues, no stalls, stall_cnt=0;
//   done pulses 4 cycles after last issue + 1.
// - Load {ADD r10=r3+r5; SUB r14=r10-r5; HLT} -> exactly 2 bubbles between issues, stall_cnt=2;
//   SUB fields rs1=10 rs2=5 rd=14 func=1 addr=128.
// - Dependency on the instruction two back (ADD rd=10; MUL rd=12; SUB rs1=10) -> 1 bubble; stall_cnt=1.
// - 16 independent instructions, no HLT -> 16 consecutive issue_valid cycles, pc stops at 15, no wrap, done once.
// - abort during a stall in RUN -> next cycle busy=0, issue_valid=0, done never pulses;
//   new start reissues from pc=0.
// - rst asserted mid-RUN between edges -> outputs 0 immediately;
//   prog_we while busy ignored (memory readback after run unchanged).

Source files
------------

// File: rtl/pipe_issue_unit_if.sv
// Issue-unit bus: program load and run control toward the unit, issued
// instruction fields and status back toward the pipeline / host.
interface pipe_issue_unit_if #(
   parameter int PAW = 4
);
   logic           prog_we;
   logic [PAW-1:0] prog_waddr;
   logic [23:0]    prog_wdata;
   logic           start;
   logic           abort;
   logic [3:0]     rs1;
   logic [3:0]     rs2;
   logic [3:0]     rd;
   logic [3:0]     func;
   logic [7:0]     addr;
   logic           issue_valid;
   logic           busy;
   logic           done;
   logic [7:0]     stall_cnt;

   modport master (
      input  prog_we, prog_waddr, prog_wdata, start, abort,
      output rs1, rs2, rd, func, addr, issue_valid, busy, done, stall_cnt
   );

   modport slave (
      output prog_we, prog_waddr, prog_wdata, start, abort,
      input  rs1, rs2, rd, func, addr, issue_valid, busy, done, stall_cnt
   );
endinterface

// File: rtl/pipe_issue_unit.sv
// Program-driven instruction issuer for the 4-stage register/ALU/memory pipeline,
// inserting bubbles on read-after-write hazards against recently issued destinations.
module pipe_issue_unit #(
   parameter int         PROG_DEPTH = 16,
   parameter int         PAW        = 4,
   parameter int         HAZ_DEPTH  = 2,
   parameter logic [3:0] HLT_FUNC   = 4'hF
) (
   input  logic              clk1,
   input  logic              rst,
   pipe_issue_unit_if.master bus
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t               state_r;
   logic [PAW-1:0]       pc_r;
   logic [1:0]           drain_cnt_r;
   logic [23:0]          mem_r [PROG_DEPTH];
   logic [HAZ_DEPTH-1:0] win_valid_r;
   logic [3:0]           win_rd_r [HAZ_DEPTH];

   logic [3:0]           rs1_r;
   logic [3:0]           rs2_r;
   logic [3:0]           rd_r;
   logic [3:0]           func_r;
   logic [7:0]           addr_r;
   logic                 issue_valid_r;
   logic                 busy_r;
   logic                 done_r;
   logic [7:0]           stall_cnt_r;

   logic [23:0]          word_s;
   logic [3:0]           w_func_s;
   logic [3:0]           w_rd_s;
   logic [3:0]           w_rs1_s;
   logic [3:0]           w_rs2_s;
   logic [7:0]           w_addr_s;
   logic                 is_hlt_s;
   logic                 hazard_s;
   logic                 issue_s;
   logic                 last_pc_s;

   // Decode the word at pc and test its sources against the in-flight destinations
   always_comb begin
      word_s   = mem_r[pc_r];
      w_func_s = word_s[23:20];
      w_rd_s   = word_s[19:16];
      w_rs1_s  = word_s[15:12];
      w_rs2_s  = word_s[11:8];
      w_addr_s = word_s[7:0];
      is_hlt_s = (w_func_s == HLT_FUNC);
      hazard_s = 1'b0;
      for (int i = 0; i < HAZ_DEPTH; i++) begin
         if (win_valid_r[i] && ((win_rd_r[i] == w_rs1_s) || (win_rd_r[i] == w_rs2_s))) begin
            hazard_s = 1'b1;
         end else begin
            hazard_s = hazard_s;
         end
      end
      issue_s   = (state_r == S_RUN) && !bus.abort && !is_hlt_s && !hazard_s;
      last_pc_s = (pc_r == PAW'(PROG_DEPTH - 1));
   end

   // Program store: writable only while idle and deliberately left out of reset
   always_ff @(posedge clk1) begin
      if (bus.prog_we && (state_r == S_IDLE)) begin
         mem_r[bus.prog_waddr] <= bus.prog_wdata;
      end else begin
         mem_r[pc_r] <= mem_r[pc_r];
      end
   end

   // Destination window advances every RUN edge, so bubbles age producers out as well
   always_ff @(posedge clk1 or posedge rst) begin
      if (rst) begin
         win_valid_r <= {HAZ_DEPTH{1'b0}};
         for (int i = 0; i < HAZ_DEPTH; i++) begin
            win_rd_r[i] <= 4'h0;
         end
      end else if (bus.abort || (state_r != S_RUN)) begin
         win_valid_r <= {HAZ_DEPTH{1'b0}};
         for (int i = 0; i < HAZ_DEPTH; i++) begin
            win_rd_r[i] <= 4'h0;
         end
      end else begin
         win_valid_r[0] <= issue_s;
         win_rd_r[0]    <= w_rd_s;
         for (int i = 1; i < HAZ_DEPTH; i++) begin
            win_valid_r[i] <= win_valid_r[i-1];
            win_rd_r[i]    <= win_rd_r[i-1];
         end
      end
   end

   // Run-control FSM with all pipeline-facing outputs registered
   always_ff @(posedge clk1 or posedge rst) begin
      if (rst) begin
         state_r       <= S_IDLE;
         pc_r          <= {PAW{1'b0}};
         drain_cnt_r   <= 2'd0;
         rs1_r         <= 4'h0;
         rs2_r         <= 4'h0;
         rd_r          <= 4'h0;
         func_r        <= 4'h0;
         addr_r        <= 8'h00;
         issue_valid_r <= 1'b0;
         busy_r        <= 1'b0;
         done_r        <= 1'b0;
         stall_cnt_r   <= 8'h00;
      end else if (bus.abort) begin
         state_r       <= S_IDLE;
         drain_cnt_r   <= 2'd0;
         issue_valid_r <= 1'b0;
         busy_r        <= 1'b0;
         done_r        <= 1'b0;
      end else begin
         case (state_r)
            S_IDLE: begin
               issue_valid_r <= 1'b0;
               done_r        <= 1'b0;
               if (bus.start && !bus.prog_we) begin
                  state_r     <= S_RUN;
                  pc_r        <= {PAW{1'b0}};
                  stall_cnt_r <= 8'h00;
                  busy_r      <= 1'b1;
               end else begin
                  state_r <= S_IDLE;
                  busy_r  <= 1'b0;
               end
            end
            S_RUN: begin
               if (is_hlt_s) begin
                  state_r       <= S_DRAIN;
                  drain_cnt_r   <= 2'd0;
                  issue_valid_r <= 1'b0;
               end else if (hazard_s) begin
                  issue_valid_r <= 1'b0;
                  if (stall_cnt_r != 8'hFF) begin
                     stall_cnt_r <= stall_cnt_r + 8'd1;
                  end else begin
                     stall_cnt_r <= stall_cnt_r;
                  end
               end else begin
                  rs1_r         <= w_rs1_s;
                  rs2_r         <= w_rs2_s;
                  rd_r          <= w_rd_s;
                  func_r        <= w_func_s;
                  addr_r        <= w_addr_s;
                  issue_valid_r <= 1'b1;
                  // The last program slot ends the run rather than wrapping to 0
                  if (last_pc_s) begin
                     state_r     <= S_DRAIN;
                     drain_cnt_r <= 2'd0;
                  end else begin
                     pc_r <= pc_r + PAW'(1);
                  end
               end
            end
            S_DRAIN: begin
               issue_valid_r <= 1'b0;
               if (drain_cnt_r == 2'd3) begin
                  state_r <= S_DONE;
                  done_r  <= 1'b1;
               end else begin
                  drain_cnt_r <= drain_cnt_r + 2'd1;
               end
            end
            S_DONE: begin
               state_r <= S_IDLE;
               done_r  <= 1'b0;
               busy_r  <= 1'b0;
            end
            default: begin
               state_r       <= S_IDLE;
               issue_valid_r <= 1'b0;
               busy_r        <= 1'b0;
               done_r        <= 1'b0;
            end
         endcase
      end
   end

   assign bus.rs1         = rs1_r;
   assign bus.rs2         = rs2_r;
   assign bus.rd          = rd_r;
   assign bus.func        = func_r;
   assign bus.addr        = addr_r;
   assign bus.issue_valid = issue_valid_r;
   assign bus.busy        = busy_r;
   assign bus.done        = done_r;
   assign bus.stall_cnt   = stall_cnt_r;

endmodule
